// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared fetch/decode types and constants
package core_pkg;

    localparam int ILEN = 32;
    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_DROP
    } fetch_state_t;

    typedef struct packed {
        logic [31:0]     pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - power-of-two FIFO of fetched {pc, instr} entries with flush
module fetch_fifo
    import core_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push,
    input  fetch_entry_t  din,
    input  logic          pop,
    input  logic          flush,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output fetch_entry_t  head
);

    localparam int AW = CW - 1;
    localparam logic [AW-1:0] PTR_MASK = AW'(DEPTH - 1);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CW'(DEPTH));
    assign count   = cnt_q;
    assign head    = mem_q[rd_q];
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && !flush;

    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (flush) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_pop) begin
                rd_d = (rd_q + AW'(1)) & PTR_MASK;
            end
            if (do_push) begin
                wr_d = (wr_q + AW'(1)) & PTR_MASK;
            end
            cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
            if (do_push) begin
                mem_q[wr_q] <= din;
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC generation, imem request/response and decoder FIFO; FETCH_STALL_CNT_EN adds starvation counter
module fetch_unit
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rstn,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] stall_cnt
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    fetch_state_t  state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic          started_q;
    logic          req_hs, rsp_push;
    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    fetch_entry_t  fifo_din, fifo_head;

    // Requests are held off for one edge after reset and whenever the FIFO has no free slot.
    assign imem_req_valid = started_q && (state_q == S_REQ) && (fifo_count < CW'(FIFO_DEPTH));
    assign imem_addr      = pc_q & WORD_MASK;
    assign req_hs         = imem_req_valid && imem_req_ready;

    assign out_valid = !fifo_empty;
    assign out_instr = fifo_head.instr;
    assign out_pc    = fifo_head.pc;
    assign fifo_pop  = out_valid && out_ready;
    assign fifo_push = rsp_push && (!fifo_full || fifo_pop);
    assign fifo_din  = {pc_q, imem_rsp_data};

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        rsp_push = 1'b0;
        case (state_q)
            S_REQ: begin
                if (req_hs) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    rsp_push = 1'b1;
                    pc_d     = pc_q + 32'd4;
                    state_d  = S_REQ;
                end
            end
            S_DROP: begin
                if (imem_rsp_valid) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
        // A redirect orphans any accepted-but-unanswered request; S_DROP swallows its response.
        if (redirect_valid) begin
            rsp_push = 1'b0;
            pc_d     = redirect_pc & WORD_MASK;
            if (state_q == S_REQ) begin
                state_d = req_hs ? S_DROP : S_REQ;
            end else begin
                state_d = imem_rsp_valid ? S_REQ : S_DROP;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_REQ;
            pc_q      <= RESET_PC & WORD_MASK;
            started_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            started_q <= 1'b1;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .flush (redirect_valid),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count),
        .head  (fifo_head)
    );

`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;
    logic        redir_q;

    // Starvation right after a redirect is expected refill latency, not a stall.
    always_comb begin
        stall_d = stall_q;
        if (out_ready && !out_valid && !redirect_valid && !redir_q && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_q <= 32'h0;
            redir_q <= 1'b0;
        end else begin
            stall_q <= stall_d;
            redir_q <= redirect_valid;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with randomized memory and decoder
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] WMASK  = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        rstn;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid, out_ready;
    logic [31:0] out_instr, out_pc, stall_cnt;

    fetch_unit #(
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .stall_cnt      (stall_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_pops   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    // Expected decoder-visible PCs: a linear run of words from the last redirect target.
    logic [31:0] exp_pc_q[$];

    task automatic new_epoch(input logic [31:0] target);
        exp_pc_q.delete();
        for (int i = 0; i < 512; i++) exp_pc_q.push_back((target & WMASK) + 32'(4 * i));
    endtask

    // Memory model
    int          lat_min = 1, lat_max = 1;
    bit          ready_always = 1'b1;
    int          ready_lo_n = 0;
    bit          pend = 1'b0;
    logic [31:0] pend_addr;
    int          pend_left;
    bit          hs_seen = 1'b0;
    logic [31:0] hs_addr;

    always @(negedge clk) begin
        hs_seen = rstn && imem_req_valid && imem_req_ready;
        hs_addr = imem_addr;
    end

    always @(posedge clk) begin
        #2;
        imem_rsp_valid = 1'b0;
        if (!rstn) begin
            pend = 1'b0;
        end else begin
            if (hs_seen) begin
                pend      = 1'b1;
                pend_addr = hs_addr;
                pend_left = $urandom_range(lat_max, lat_min);
            end
            if (pend) begin
                if (pend_left <= 1) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = mem_word(pend_addr);
                    pend           = 1'b0;
                end else begin
                    pend_left--;
                end
            end
        end
        if (ready_lo_n > 0) begin
            imem_req_ready = 1'b0;
            ready_lo_n--;
        end else begin
            imem_req_ready = ready_always ? 1'b1 : ($urandom_range(3, 0) != 0);
        end
    end

    // Monitor
    logic [31:0] stall_model = 32'h0;
    bit          prev_redir = 1'b0, prev_hold = 1'b0, first_flag = 1'b1;
    logic [31:0] prev_addr, first_exp = RST_PC & WMASK, e;

    always @(negedge clk) begin
        if (!rstn) begin
            stall_model = 32'h0;
            prev_redir  = 1'b0;
            prev_hold   = 1'b0;
            first_flag  = 1'b1;
            first_exp   = RST_PC & WMASK;
        end else begin
            check("stall_cnt", stall_cnt, stall_model);
`ifdef FETCH_STALL_CNT_EN
            if (out_ready && !out_valid && !redirect_valid && !prev_redir && stall_model != 32'hFFFF_FFFF)
                stall_model++;
`endif
            prev_redir = redirect_valid;
            if (prev_hold) begin
                check("req_hold_valid", 32'(imem_req_valid), 32'd1);
                check("req_hold_addr", imem_addr, prev_addr);
            end
            prev_hold = imem_req_valid && !imem_req_ready && !redirect_valid;
            prev_addr = imem_addr;
            if (imem_req_valid) check("addr_align", 32'(imem_addr[1:0]), 32'd0);
            if (imem_req_valid && imem_req_ready) begin
                check("one_outstanding", 32'(pend | imem_rsp_valid), 32'd0);
                if (first_flag && !redirect_valid) begin
                    check("first_addr", imem_addr, first_exp);
                    first_flag = 1'b0;
                end
            end
            if (redirect_valid) begin
                first_flag = 1'b1;
                first_exp  = redirect_pc & WMASK;
            end
            if (out_valid && out_ready && !redirect_valid) begin
                n_pops++;
                if (exp_pc_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_output: got pc %h, expected no output", out_pc);
                end else begin
                    e = exp_pc_q.pop_front();
                    check("out_pc", out_pc, e);
                    check("out_instr", out_instr, mem_word(e));
                end
            end
        end
    end

    // Stimulus
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect_to(input logic [31:0] t);
        redirect_valid = 1'b1;
        redirect_pc    = t;
        new_epoch(t);
        tick();
        redirect_valid = 1'b0;
    endtask

    task automatic wait_hs();
        bit got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) got = 1'b1;
        end
        if (!got) begin
            n_checks++;
            $display("FAIL wait_hs: got no accepted request in 50 cycles, expected one");
        end
        tick();
    endtask

    int p0;

    initial begin
        rstn           = 1'b0;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        imem_req_ready = 1'b0;
        new_epoch(RST_PC);
        @(negedge clk);
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_addr", imem_addr, RST_PC);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_stall", stall_cnt, 32'h0);
        tick();
        tick();
        rstn = 1'b1;
        @(negedge clk);
        check("req_before_first_edge", 32'(imem_req_valid), 32'd0);
        tick();

        // Sustained 1-cycle memory: one instruction per two cycles
        repeat (10) tick();
        p0 = n_pops;
        repeat (40) tick();
        check("throughput_40cyc", 32'(n_pops - p0), 32'd20);

        // Decoder stalled: FIFO fills with PCs 0 and 4, requests stop
        out_ready = 1'b0;
        redirect_to(32'h0);
        repeat (10) tick();
        @(negedge clk);
        check("full_req_valid", 32'(imem_req_valid), 32'd0);
        check("full_out_valid", 32'(out_valid), 32'd1);
        check("full_head_pc", out_pc, 32'h0);
        tick();
        out_ready = 1'b1;
        repeat (10) tick();

        // Redirect while waiting on a 3-cycle response
        lat_min = 3;
        lat_max = 3;
        wait_hs();
        redirect_to(32'h100);
        @(negedge clk);
        check("redir_wait_empty", 32'(out_valid), 32'd0);
        tick();
        repeat (20) tick();

        // Redirect coinciding with a response and a pop, then memory not ready
        lat_min = 1;
        lat_max = 1;
        out_ready = 1'b0;
        redirect_to(32'h300);
        wait_hs();
        wait_hs();
        out_ready  = 1'b1;
        ready_lo_n = 5;
        redirect_to(32'h200);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_addr", imem_addr, 32'h200);
            check("stall_req_valid", 32'(imem_req_valid), 32'd1);
            check("stall_out_valid", 32'(out_valid), 32'd0);
            tick();
        end
        repeat (10) tick();

        // Address wrap
        redirect_to(32'hFFFF_FFF8);
        repeat (16) tick();

        // Reset in the middle of a wait
        lat_min = 3;
        lat_max = 3;
        wait_hs();
        rstn = 1'b0;
        new_epoch(RST_PC);
        @(negedge clk);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_addr", imem_addr, RST_PC);
        check("midrst_req_valid", 32'(imem_req_valid), 32'd0);
        tick();
        tick();
        rstn = 1'b1;
        repeat (10) tick();

        // Randomized traffic
        lat_min = 1;
        lat_max = 3;
        ready_always = 1'b0;
        for (int i = 0; i < 600; i++) begin
            out_ready = ($urandom_range(3, 0) != 0);
            if ($urandom_range(19, 0) == 0) begin
                redirect_to($urandom());
            end
            tick();
        end
        out_ready = 1'b1;
        repeat (20) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
